mem_write_checker: RTL and testbench



---
 rtl/mem_check_pkg.sv | 24 ++
 rtl/exp_table.sv | 36 +++
 rtl/mem_write_checker.sv | 159 +++++++++++++++
 tb/tb_mem_write_checker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_check_pkg.sv
//------------------------------------------------------------------------------
// mem_check_pkg
// Checker FSM state encoding and failure-code constants.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    localparam logic [1:0] FC_NONE        = 2'd0;
    localparam logic [1:0] FC_WRONG_WRITE = 2'd1;
    localparam logic [1:0] FC_TIMEOUT     = 2'd2;
    localparam logic [1:0] FC_STALL       = 2'd3;

endpackage

`default_nettype wire

// File: rtl/exp_table.sv
//------------------------------------------------------------------------------
// exp_table
// Expected (address, data) register file: synchronous write, combinational read.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module exp_table #(
    parameter int DW      = 32,
    parameter int NUM_EXP = 8,
    parameter int IW      = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  logic [DW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_adr,
    output logic [DW-1:0] rd_data
);

    // No reset: contents survive reset so a run can be replayed without reloading.
    logic [2*DW-1:0] mem [NUM_EXP];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= {wr_adr, wr_data};
        end
    end

    assign {rd_adr, rd_data} = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/mem_write_checker.sv
//------------------------------------------------------------------------------
// mem_write_checker
// In-order checker of data-memory writes against a loadable expected table,
// with sticky pass/fail, timeout and controller-stall detection.
// Optional macro MEM_CHECK_CAPTURE_EN adds fail_adr/fail_data/fail_idx outputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int DW          = 32,
    parameter int NUM_EXP     = 8,
    parameter int IGNORE_ADR  = 96,
    parameter int IGNORE_EN   = 1,
    parameter int MAX_CYCLES  = 1000,
    parameter int STALL_LIMIT = 16,
    parameter int SW          = 4,
    localparam int IW         = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int LW         = $clog2(NUM_EXP) + 1,
    localparam int SCW        = $clog2(STALL_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [DW-1:0] Adr,
    input  logic [DW-1:0] WriteData,
    input  logic [SW-1:0] state,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [DW-1:0] exp_adr,
    input  logic [DW-1:0] exp_data,
    input  logic [LW-1:0] exp_len,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [LW-1:0] match_cnt,
    output logic [7:0]    ign_cnt,
`ifdef MEM_CHECK_CAPTURE_EN
    output logic [DW-1:0] fail_adr,
    output logic [DW-1:0] fail_data,
    output logic [LW-1:0] fail_idx,
`endif
    output logic [31:0]   cyc_cnt
);

    chk_state_t     st;
    logic [LW-1:0]  ptr;
    logic [LW-1:0]  len_q;
    logic [SCW-1:0] stall_cnt;
    logic [SW-1:0]  prev_state;
    logic [DW-1:0]  cur_adr;
    logic [DW-1:0]  cur_data;

    logic [31:0]    cyc_next;
    logic [SCW-1:0] stall_next;
    logic           hit;
    logic           ign_hit;
    logic           go_pass;
    logic           go_fail;
    logic [1:0]     go_code;

    exp_table #(
        .DW      (DW),
        .NUM_EXP (NUM_EXP),
        .IW      (IW)
    ) u_exp_table (
        .clk     (clk),
        .we      (exp_we & reset),
        .wr_idx  (exp_idx),
        .wr_adr  (exp_adr),
        .wr_data (exp_data),
        .rd_idx  (ptr[IW-1:0]),
        .rd_adr  (cur_adr),
        .rd_data (cur_data)
    );

    // Case equality makes X/Z on the bus a mismatch in simulation.
    always_comb begin
        cyc_next   = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
        stall_next = (state != prev_state) ? '0 : stall_cnt + 1'b1;
        hit        = MemWrite && (ptr < len_q) && (Adr === cur_adr) && (WriteData === cur_data);
        ign_hit    = MemWrite && (IGNORE_EN != 0) && (Adr === DW'(IGNORE_ADR));
        go_pass    = 1'b0;
        go_fail    = 1'b0;
        go_code    = FC_NONE;
        if (len_q == '0) begin
            go_pass = 1'b1;
        end else if (hit && ((ptr + 1'b1) == len_q)) begin
            go_pass = 1'b1;
        end else if (MemWrite && !hit && !ign_hit) begin
            go_fail = 1'b1;
            go_code = FC_WRONG_WRITE;
        end else if (cyc_next >= 32'(MAX_CYCLES)) begin
            go_fail = 1'b1;
            go_code = FC_TIMEOUT;
        end else if (stall_next >= SCW'(STALL_LIMIT)) begin
            go_fail = 1'b1;
            go_code = FC_STALL;
        end
    end

    always_ff @(posedge clk) begin
        prev_state <= state;
        if (reset) begin
            st        <= ST_IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
            match_cnt <= '0;
            ign_cnt   <= '0;
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            ptr       <= '0;
            len_q     <= (exp_len > LW'(NUM_EXP)) ? LW'(NUM_EXP) : exp_len;
`ifdef MEM_CHECK_CAPTURE_EN
            fail_adr  <= '0;
            fail_data <= '0;
            fail_idx  <= '0;
`endif
        end else begin
            case (st)
                ST_IDLE: st <= ST_RUN;
                ST_RUN: begin
                    cyc_cnt   <= cyc_next;
                    stall_cnt <= stall_next;
                    if (hit) begin
                        ptr       <= ptr + 1'b1;
                        match_cnt <= match_cnt + 1'b1;
                    end else if (ign_hit && (ign_cnt != 8'hFF)) begin
                        ign_cnt <= ign_cnt + 8'd1;
                    end
                    if (go_pass) begin
                        st   <= ST_PASS;
                        pass <= 1'b1;
                        done <= 1'b1;
                    end else if (go_fail) begin
                        st        <= ST_FAIL;
                        fail      <= 1'b1;
                        done      <= 1'b1;
                        fail_code <= go_code;
`ifdef MEM_CHECK_CAPTURE_EN
                        fail_adr  <= (go_code == FC_WRONG_WRITE) ? Adr : '0;
                        fail_data <= (go_code == FC_WRONG_WRITE) ? WriteData : '0;
                        fail_idx  <= ptr;
`endif
                    end
                end
                default: st <= st;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
//------------------------------------------------------------------------------
// tb_mem_write_checker
// Randomised and directed bench with a behavioural reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_checker;

    localparam int DW = 32, NUM_EXP = 8, IW = 3, LW = 4, SW = 4;
    localparam int MAXC = 50, STL = 16, IGN = 96;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          MemWrite = 1'b0;
    logic [DW-1:0] Adr = '0;
    logic [DW-1:0] WriteData = '0;
    logic [SW-1:0] state = '0;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic [DW-1:0] exp_adr = '0;
    logic [DW-1:0] exp_data = '0;
    logic [LW-1:0] exp_len = '0;
    logic          done, pass, fail;
    logic [1:0]    fail_code;
    logic [LW-1:0] match_cnt;
    logic [7:0]    ign_cnt;
    logic [31:0]   cyc_cnt;
`ifdef MEM_CHECK_CAPTURE_EN
    logic [DW-1:0] fail_adr, fail_data;
    logic [LW-1:0] fail_idx;
`endif

    always #5 clk = ~clk;

    mem_write_checker #(
        .DW(DW), .NUM_EXP(NUM_EXP), .IGNORE_ADR(IGN), .IGNORE_EN(1),
        .MAX_CYCLES(MAXC), .STALL_LIMIT(STL), .SW(SW)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
        .state(state), .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr),
        .exp_data(exp_data), .exp_len(exp_len), .done(done), .pass(pass), .fail(fail),
        .fail_code(fail_code), .match_cnt(match_cnt), .ign_cnt(ign_cnt),
`ifdef MEM_CHECK_CAPTURE_EN
        .fail_adr(fail_adr), .fail_data(fail_data), .fail_idx(fail_idx),
`endif
        .cyc_cnt(cyc_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit hold_state = 1'b0;
    bit started = 1'b0;

    // Reference model: phase 0 = waiting after reset, 1 = checking, 2 = verdict reached.
    int            m_phase = 0;
    bit            m_pass, m_fail;
    int            m_code, m_matched, m_ign, m_cyc, m_stall, m_len;
    logic [SW-1:0] m_prev;
    logic [DW-1:0] m_fadr, m_fdata;
    int            m_fidx;
    logic [DW-1:0] tab_adr [NUM_EXP];
    logic [DW-1:0] tab_data[NUM_EXP];
    logic [DW-1:0] ld_adr  [NUM_EXP];
    logic [DW-1:0] ld_data [NUM_EXP];

    function automatic void m_verdict_fail(input int code, input logic [DW-1:0] a, input logic [DW-1:0] d);
        m_phase = 2; m_fail = 1'b1; m_code = code;
        m_fadr = a; m_fdata = d; m_fidx = m_matched;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            if (exp_we) begin
                tab_adr[exp_idx]  = exp_adr;
                tab_data[exp_idx] = exp_data;
            end
            m_len = (int'(exp_len) > NUM_EXP) ? NUM_EXP : int'(exp_len);
            m_phase = 0; m_pass = 0; m_fail = 0; m_code = 0;
            m_matched = 0; m_ign = 0; m_cyc = 0; m_stall = 0;
            m_fadr = '0; m_fdata = '0; m_fidx = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_cyc   = m_cyc + 1;
            m_stall = (state != m_prev) ? 0 : m_stall + 1;
            if (m_len == 0) begin
                m_phase = 2; m_pass = 1'b1;
            end else if (MemWrite && m_matched < m_len && Adr === tab_adr[m_matched]
                         && WriteData === tab_data[m_matched]) begin
                m_matched = m_matched + 1;
                if (m_matched == m_len) begin
                    m_phase = 2; m_pass = 1'b1;
                end
            end else if (MemWrite && Adr === IGN) begin
                m_ign = (m_ign < 255) ? m_ign + 1 : 255;
            end else if (MemWrite) begin
                m_verdict_fail(1, Adr, WriteData);
            end
            if (m_phase == 1) begin
                if (m_cyc >= MAXC)       m_verdict_fail(2, '0, '0);
                else if (m_stall >= STL) m_verdict_fail(3, '0, '0);
            end
        end
        m_prev = state;
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({done, pass, fail, fail_code, match_cnt, ign_cnt, cyc_cnt} !==
                {m_pass | m_fail, m_pass, m_fail, 2'(m_code), LW'(m_matched), 8'(m_ign), 32'(m_cyc)}) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got d/p/f=%0d%0d%0d code=%0d match=%0d ign=%0d cyc=%0d want d/p/f=%0d%0d%0d code=%0d match=%0d ign=%0d cyc=%0d",
                         $time, done, pass, fail, fail_code, match_cnt, ign_cnt, cyc_cnt,
                         m_pass | m_fail, m_pass, m_fail, m_code, m_matched, m_ign, m_cyc);
            end
`ifdef MEM_CHECK_CAPTURE_EN
            checks++;
            if ({fail_adr, fail_data, fail_idx} !== {m_fadr, m_fdata, LW'(m_fidx)}) begin
                errors++;
                $display("FAIL capture_compare t=%0t got %h/%h/%0d want %h/%h/%0d",
                         $time, fail_adr, fail_data, fail_idx, m_fadr, m_fdata, m_fidx);
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (!hold_state) state = state + 1'b1;
    end

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Loads the first n entries of ld_* during reset, releases reset and
    // returns just before the first checking edge.
    task automatic load_table(input int n, input int len);
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_we = 1'b1; exp_idx = IW'(i); exp_adr = ld_adr[i]; exp_data = ld_data[i];
            @(negedge clk);
        end
        exp_we = 1'b0; exp_len = LW'(len);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
        MemWrite = 1'b1; Adr = a; WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic run_until_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_bound: got done=0 after %0d cycles, want done=1", n);
        end
    endtask

    task automatic random_test();
        int len, n, r, k;
        len = $urandom_range(0, NUM_EXP);
        hold_state = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < NUM_EXP; i++) begin
            ld_adr[i]  = 32'(64 + 4 * $urandom_range(0, 8));
            ld_data[i] = 32'($urandom_range(0, 3));
        end
        load_table(NUM_EXP, len);
        n = 0;
        while (!done && n < 70) begin
            r = $urandom_range(0, 99);
            k = (m_matched < NUM_EXP) ? m_matched : 0;
            if (m_len == 0 || r < 30) @(negedge clk);
            else if (r < 80) wr(tab_adr[k], tab_data[k]);
            else if (r < 94) wr(32'(IGN), 32'($urandom));
            else wr(32'(64 + 4 * $urandom_range(0, 8)), 32'($urandom_range(0, 3)));
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL random_bound: got done=0, want done=1");
        end
        @(negedge clk);
        hold_state = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_code", fail_code, 0);
        check("rst_match", match_cnt, 0);
        check("rst_cyc", cyc_cnt, 0);

        // Ignored write then the single expected write.
        ld_adr[0] = 100; ld_data[0] = 7;
        load_table(1, 1);
        wr(96, 0);
        check("ign_pass_early", pass, 0);
        wr(100, 7);
        check("ign_cnt", ign_cnt, 1);
        check("ign_pass", pass, 1);
        check("ign_code", fail_code, 0);

        // Wrong data.
        load_table(1, 1);
        wr(100, 8);
        check("wd_fail", fail, 1);
        check("wd_code", fail_code, 1);
        check("wd_match", match_cnt, 0);
`ifdef MEM_CHECK_CAPTURE_EN
        check("wd_fail_adr", fail_adr, 100);
        check("wd_fail_data", fail_data, 8);
`endif

        // Three entries: out of order, then in order (table retained).
        ld_adr[0] = 32'h10; ld_data[0] = 1;
        ld_adr[1] = 32'h14; ld_data[1] = 2;
        ld_adr[2] = 32'h18; ld_data[2] = 3;
        load_table(3, 3);
        wr(32'h14, 2);
        check("ooo_code", fail_code, 1);
        load_table(0, 3);
        wr(32'h10, 1); wr(32'h14, 2); wr(32'h18, 3);
        check("ino_pass", pass, 1);
        check("ino_match", match_cnt, 3);

        // Timeout with state toggling.
        ld_adr[0] = 100; ld_data[0] = 7;
        load_table(1, 1);
        run_until_done(60);
        check("to_code", fail_code, 2);
        check("to_cyc", cyc_cnt, 50);

        // Stall with state held.
        hold_state = 1'b1;
        load_table(0, 1);
        run_until_done(60);
        check("st_code", fail_code, 3);
        check("st_cyc", cyc_cnt, 16);
        hold_state = 1'b0;

        // Final match on the cycle the budget runs out.
        load_table(0, 1);
        repeat (49) @(negedge clk);
        wr(100, 7);
        check("edge_pass", pass, 1);
        check("edge_fail", fail, 0);
        check("edge_cyc", cyc_cnt, 50);

        // Reset mid-run after one match, then replay.
        ld_adr[0] = 32'h10; ld_data[0] = 1;
        load_table(3, 3);
        wr(32'h10, 1);
        check("mid_match1", match_cnt, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_match", match_cnt, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        wr(32'h10, 1); wr(32'h14, 2); wr(32'h18, 3);
        check("mid_replay_pass", pass, 1);
        check("mid_replay_match", match_cnt, 3);

        // Empty table.
        load_table(0, 0);
        @(negedge clk);
        check("len0_pass", pass, 1);
        check("len0_fail", fail, 0);

        for (int it = 0; it < 40; it++) random_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
